// File: rtl/stage3_pkg.sv
// Shared EX-stage definitions: datapath/register-index widths and ALU op encodings.
// Also consumed by the decode stage so both sides agree on aluop values.
package stage3_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RegIdxW = 6;

  typedef enum logic [2:0] {
    AluAdd   = 3'b000,
    AluSub   = 3'b001,
    AluNeg   = 3'b010,
    AluPassB = 3'b011,
    AluAnd   = 3'b100,
    AluOr    = 3'b101,
    AluZero0 = 3'b110,
    AluZero1 = 3'b111
  } alu_op_e;

endpackage

// File: rtl/stage3_alu.sv
// Combinational EX-stage ALU with zero / negative detect on the result.
// Ports:
//   a, b    in  XLEN  operands
//   op      in  3     operation code (stage3_pkg::alu_op_e)
//   result  out XLEN  ALU result, modulo 2^XLEN
//   zero    out 1     result == 0
//   neg     out 1     result sign bit
module stage3_alu
  import stage3_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            neg
);

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      AluAdd:   result = a + b;
      AluSub:   result = a - b;
      AluNeg:   result = '0 - a;
      AluPassB: result = b;
      AluAnd:   result = a & b;
      AluOr:    result = a | b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[XLEN-1];

endmodule

// File: rtl/stage3.sv
// EX stage: operand select, ALU, zero/negative flags, branch resolution and the
// EX/MEM pipeline register. All outputs are registered (one-cycle latency).
// A taken branch in EX/MEM squashes the instruction being captured behind it.
// Optional build macro STAGE3_FWD_EN enables EX/MEM-to-EX operand forwarding;
// without it rs1/rs2 are ignored.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, stall, flush        slot valid, hold everything, squash capture
//   imm, rd1, rd2, pc             immediate, source operands, instruction PC
//   rd, rs1, rs2                  register indices
//   brz, brn, j, regw, memw,
//   memr, alusrc, aluop           decoded control
//   out_valid, out_regw, out_memw,
//   out_memr, out_result,
//   out_store, out_rd             EX/MEM register
//   out_taken, out_target         redirect to fetch
module stage3
  import stage3_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    rd1,
  input  logic [XLEN-1:0]    rd2,
  input  logic [XLEN-1:0]    pc,
  input  logic [RegIdxW-1:0] rd,
  input  logic [RegIdxW-1:0] rs1,
  input  logic [RegIdxW-1:0] rs2,
  input  logic               brz,
  input  logic               brn,
  input  logic               j,
  input  logic               regw,
  input  logic               memw,
  input  logic               memr,
  input  logic               alusrc,
  input  logic [2:0]         aluop,
  output logic               out_valid,
  output logic               out_regw,
  output logic               out_memw,
  output logic               out_memr,
  output logic [XLEN-1:0]    out_result,
  output logic [XLEN-1:0]    out_store,
  output logic [RegIdxW-1:0] out_rd,
  output logic               out_taken,
  output logic [XLEN-1:0]    out_target
);

  logic               valid_q, regw_q, memw_q, memr_q, taken_q;
  logic               valid_d, regw_d, memw_d, memr_d, taken_d;
  logic [XLEN-1:0]    result_q, store_q, target_q;
  logic [XLEN-1:0]    result_d, store_d, target_d;
  logic [RegIdxW-1:0] rd_q, rd_d;
  logic               z_flag, n_flag;

  logic [XLEN-1:0] src1, src2, op_b, alu_result;
  logic            alu_zero, alu_neg;
  logic            capture, flag_upd;
  logic            unused_pc;

  assign unused_pc = ^pc;

`ifdef STAGE3_FWD_EN
  logic fwd_ok;
  // Loads are not forwardable: their data is not known until MEM.
  assign fwd_ok = valid_q & regw_q & ~memr_q;
  assign src1   = (fwd_ok && (rs1 == rd_q)) ? result_q : rd1;
  assign src2   = (fwd_ok && (rs2 == rd_q)) ? result_q : rd2;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign src1      = rd1;
  assign src2      = rd2;
`endif

  assign op_b = alusrc ? imm : src2;

  stage3_alu u_alu (
    .a      (src1),
    .b      (op_b),
    .op     (aluop),
    .result (alu_result),
    .zero   (alu_zero),
    .neg    (alu_neg)
  );

  // The slot directly behind a taken branch is the shadow slot and is killed.
  assign capture  = in_valid & ~flush & ~taken_q;
  assign flag_upd = capture & regw & ~memr;

  always_comb begin
    valid_d  = 1'b0;
    regw_d   = 1'b0;
    memw_d   = 1'b0;
    memr_d   = 1'b0;
    taken_d  = 1'b0;
    result_d = '0;
    store_d  = '0;
    target_d = '0;
    rd_d     = '0;
    if (capture) begin
      valid_d  = 1'b1;
      regw_d   = regw;
      memw_d   = memw;
      memr_d   = memr;
      // Flags here are the values before this instruction's own update.
      taken_d  = j | (brz & z_flag) | (brn & n_flag);
      result_d = alu_result;
      store_d  = src2;
      target_d = taken_d ? src1 : '0;
      rd_d     = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      memr_q   <= 1'b0;
      taken_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      target_q <= '0;
      rd_q     <= '0;
      z_flag   <= 1'b0;
      n_flag   <= 1'b0;
    end else if (!stall) begin
      valid_q  <= valid_d;
      regw_q   <= regw_d;
      memw_q   <= memw_d;
      memr_q   <= memr_d;
      taken_q  <= taken_d;
      result_q <= result_d;
      store_q  <= store_d;
      target_q <= target_d;
      rd_q     <= rd_d;
      if (flag_upd) begin
        z_flag <= alu_zero;
        n_flag <= alu_neg;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_regw   = regw_q;
  assign out_memw   = memw_q;
  assign out_memr   = memr_q;
  assign out_taken  = taken_q;
  assign out_result = result_q;
  assign out_store  = store_q;
  assign out_target = target_q;
  assign out_rd     = rd_q;

endmodule

// File: tb/tb_stage3.sv
// Table-driven bench for stage3. Each record holds one cycle of stimulus and the
// outputs/flags expected after that rising edge; records are queued as they are
// driven and popped for comparison one cycle later.
module tb_stage3;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [31:0] imm, rd1, rd2, pc;
  logic [5:0]  rd, rs1, rs2;
  logic        brz, brn, j, regw, memw, memr, alusrc;
  logic [2:0]  aluop;
  logic        out_valid, out_regw, out_memw, out_memr, out_taken;
  logic [31:0] out_result, out_store, out_target;
  logic [5:0]  out_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage3 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .imm        (imm),
    .rd1        (rd1),
    .rd2        (rd2),
    .pc         (pc),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .brz        (brz),
    .brn        (brn),
    .j          (j),
    .regw       (regw),
    .memw       (memw),
    .memr       (memr),
    .alusrc     (alusrc),
    .aluop      (aluop),
    .out_valid  (out_valid),
    .out_regw   (out_regw),
    .out_memw   (out_memw),
    .out_memr   (out_memr),
    .out_result (out_result),
    .out_store  (out_store),
    .out_rd     (out_rd),
    .out_taken  (out_taken),
    .out_target (out_target)
  );

  // mode = {rst, stall, flush, in_valid}
  // ctl  = {alusrc, regw, memw, memr, brz, brn, j}
  // e_ctl = {out_valid, out_regw, out_memw, out_memr, out_taken}; e_zn = {z_flag, n_flag}
  typedef struct {
    logic [3:0]  mode;
    logic [2:0]  op;
    logic [6:0]  ctl;
    logic [31:0] imm, rd1, rd2;
    logic [5:0]  rd, rs1, rs2;
    logic [4:0]  e_ctl;
    logic [31:0] e_tgt, e_res, e_st;
    logic [5:0]  e_rd;
    logic [1:0]  e_zn;
  } vec_t;

`ifdef STAGE3_FWD_EN
  localparam logic [31:0] FwdRes = 32'd10;
  localparam logic [31:0] FwdSt  = 32'd9;
`else
  localparam logic [31:0] FwdRes = 32'd1;
  localparam logic [31:0] FwdSt  = 32'd0;
`endif

  vec_t tbl[24];
  vec_t exp_q[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, req);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    {rst, stall, flush, in_valid} = v.mode;
    aluop = v.op;
    {alusrc, regw, memw, memr, brz, brn, j} = v.ctl;
    imm = v.imm; rd1 = v.rd1; rd2 = v.rd2;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    pc = $urandom;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard step %0d: queue empty, expected 1 entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk("ctl", idx, {27'h0, out_valid, out_regw, out_memw, out_memr, out_taken},
          {27'h0, e.e_ctl});
      chk("target", idx, out_target, e.e_tgt);
      chk("result", idx, out_result, e.e_res);
      chk("store", idx, out_store, e.e_st);
      chk("rd", idx, {26'h0, out_rd}, {26'h0, e.e_rd});
      chk("flags", idx, {30'h0, dut.z_flag, dut.n_flag}, {30'h0, e.e_zn});
    end
  endtask

  initial begin
    vec_t v;
    // reset
    tbl[0]  = '{4'b1000, 3'b000, 7'b0000000, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0, 6'd0,
                5'b00000, 32'h0, 32'h0, 32'h0, 6'd0, 2'b00};
    // SUB 5-7 -> negative
    tbl[1]  = '{4'b0001, 3'b001, 7'b0100000, 32'h0, 32'h5, 32'h7, 6'd3, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'hFFFF_FFFE, 32'h7, 6'd3, 2'b01};
    // brn taken to 0x40
    tbl[2]  = '{4'b0001, 3'b000, 7'b0000010, 32'h0, 32'h40, 32'h0, 6'd0, 6'd0, 6'd0,
                5'b10001, 32'h40, 32'h40, 32'h0, 6'd0, 2'b01};
    // shadow slot killed
    tbl[3]  = '{4'b0001, 3'b000, 7'b0100000, 32'h0, 32'h1, 32'h2, 6'd5, 6'd0, 6'd0,
                5'b00000, 32'h0, 32'h0, 32'h0, 6'd0, 2'b01};
    // ADDI -3+3 = 0
    tbl[4]  = '{4'b0001, 3'b000, 7'b1100000, 32'h3, 32'hFFFF_FFFD, 32'h11, 6'd6, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'h0, 32'h11, 6'd6, 2'b10};
    // brz taken
    tbl[5]  = '{4'b0001, 3'b000, 7'b0000100, 32'h0, 32'h80, 32'h0, 6'd0, 6'd0, 6'd0,
                5'b10001, 32'h80, 32'h80, 32'h0, 6'd0, 2'b10};
    // back-to-back jump in shadow -> squashed
    tbl[6]  = '{4'b0001, 3'b000, 7'b0000001, 32'h0, 32'h100, 32'h0, 6'd0, 6'd0, 6'd0,
                5'b00000, 32'h0, 32'h0, 32'h0, 6'd0, 2'b10};
    // AND
    tbl[7]  = '{4'b0001, 3'b100, 7'b0100000, 32'h0, 32'hF0F0, 32'hFF00, 6'd7, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'hF000, 32'hFF00, 6'd7, 2'b00};
    // three stalls with changing inputs, one with flush -> hold
    tbl[8]  = '{4'b0101, 3'b101, 7'b0100000, 32'h0, 32'h1, 32'h2, 6'd9, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'hF000, 32'hFF00, 6'd7, 2'b00};
    tbl[9]  = '{4'b0111, 3'b000, 7'b0000001, 32'h0, 32'h3, 32'h4, 6'd9, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'hF000, 32'hFF00, 6'd7, 2'b00};
    tbl[10] = '{4'b0101, 3'b010, 7'b0110001, 32'h5, 32'h5, 32'h6, 6'd1, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'hF000, 32'hFF00, 6'd7, 2'b00};
    // flush squashes
    tbl[11] = '{4'b0011, 3'b101, 7'b0110000, 32'h0, 32'h1, 32'h2, 6'd3, 6'd0, 6'd0,
                5'b00000, 32'h0, 32'h0, 32'h0, 6'd0, 2'b00};
    // OR store
    tbl[12] = '{4'b0001, 3'b101, 7'b0010000, 32'h0, 32'h0F, 32'hF0, 6'd2, 6'd0, 6'd0,
                5'b10100, 32'h0, 32'hFF, 32'hF0, 6'd2, 2'b00};
    // NEG load: flags not updated
    tbl[13] = '{4'b0001, 3'b010, 7'b0101000, 32'h0, 32'h1, 32'h0, 6'd9, 6'd0, 6'd0,
                5'b11010, 32'h0, 32'hFFFF_FFFF, 32'h0, 6'd9, 2'b00};
    // invalid slot
    tbl[14] = '{4'b0000, 3'b000, 7'b0100000, 32'h0, 32'h3, 32'h4, 6'd5, 6'd0, 6'd0,
                5'b00000, 32'h0, 32'h0, 32'h0, 6'd0, 2'b00};
    // aluop 110 / 111 give 0
    tbl[15] = '{4'b0001, 3'b110, 7'b0100000, 32'h0, 32'h5, 32'h5, 6'd1, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'h0, 32'h5, 6'd1, 2'b10};
    tbl[16] = '{4'b0001, 3'b111, 7'b0100000, 32'h0, 32'h7, 32'h9, 6'd1, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'h0, 32'h9, 6'd1, 2'b10};
    // pass B (imm)
    tbl[17] = '{4'b0001, 3'b011, 7'b1100000, 32'h1234, 32'h55, 32'hAB, 6'd2, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'h1234, 32'hAB, 6'd2, 2'b00};
    // jump, then reset while out_taken=1
    tbl[18] = '{4'b0001, 3'b000, 7'b0000001, 32'h0, 32'h200, 32'h0, 6'd0, 6'd0, 6'd0,
                5'b10001, 32'h200, 32'h200, 32'h0, 6'd0, 2'b00};
    tbl[19] = '{4'b1001, 3'b000, 7'b0100000, 32'h0, 32'h1, 32'h1, 6'd5, 6'd0, 6'd0,
                5'b00000, 32'h0, 32'h0, 32'h0, 6'd0, 2'b00};
    // first after release captured normally; brn not taken (n=0)
    tbl[20] = '{4'b0001, 3'b000, 7'b0100010, 32'h0, 32'h300, 32'h1, 6'd4, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'h301, 32'h1, 6'd4, 2'b00};
    // reset dominates stall and flush
    tbl[21] = '{4'b1111, 3'b000, 7'b0100000, 32'h0, 32'h1, 32'h1, 6'd5, 6'd0, 6'd0,
                5'b00000, 32'h0, 32'h0, 32'h0, 6'd0, 2'b00};
    // forwarding pair
    tbl[22] = '{4'b0001, 3'b000, 7'b0100000, 32'h0, 32'h4, 32'h5, 6'd4, 6'd0, 6'd0,
                5'b11000, 32'h0, 32'h9, 32'h5, 6'd4, 2'b00};
    tbl[23] = '{4'b0001, 3'b000, 7'b1100000, 32'h1, 32'h0, 32'h0, 6'd8, 6'd4, 6'd4,
                5'b11000, 32'h0, FwdRes, FwdSt, 6'd8, 2'b00};

    for (int i = 0; i < 24; i++) apply(tbl[i], i);

    // Taken jump held across a stall keeps its shadow kill pending.
    v = '{4'b0001, 3'b000, 7'b0000001, 32'h0, 32'h500, 32'h0, 6'd0, 6'd0, 6'd0,
          5'b10001, 32'h500, 32'h500, 32'h0, 6'd0, 2'b00};
    apply(v, 100);
    for (int k = 0; k < 2; k++) begin
      v.mode = 4'b0101;
      v.op   = 3'($urandom_range(0, 7));
      v.ctl  = 7'($urandom);
      v.imm  = $urandom;
      v.rd1  = $urandom;
      v.rd2  = $urandom;
      v.rd   = 6'($urandom);
      apply(v, 101 + k);
    end
    v = '{4'b0001, 3'b000, 7'b0100000, 32'h0, 32'h1, 32'h1, 6'd3, 6'd0, 6'd0,
          5'b00000, 32'h0, 32'h0, 32'h0, 6'd0, 2'b00};
    apply(v, 103);
    v.e_ctl = 5'b11000; v.e_res = 32'h2; v.e_st = 32'h1; v.e_rd = 6'd3;
    apply(v, 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
